countdown_timer_expire: RTL

Loadable down-counter, the counterpart of the up-counting overflow counter. It counts a latched start value down to zero at a programmable prescaled rate, then raises a sticky expiry flag and stops. Used by program-control logic for timeouts and delays, with start, pause and clear controls and a one-cycle expiry pulse for event logic.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/prescaler_tick.sv | 38 +++
 rtl/countdown_timer_expire.sv | 114 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
// State encoding and width defaults live here.
package timer_pkg;

  localparam int DEF_COUNTER_BITS = 32;
  localparam int DEF_DIV_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  function automatic logic is_busy(
    input timer_state_e st
  );
    return (st == ST_RUN) ||
           (st == ST_PAUSED);
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Prescaler for the countdown timer: one tick
// every div_q+1 enabled cycles.
module prescaler_tick #(
  parameter int DIV_BITS = 16
) (
  input  logic                i_CLK,
  input  logic                i_RST_N,
  input  logic                load,
  input  logic [DIV_BITS-1:0] div,
  input  logic                enable,
  input  logic                clear,
  output logic                tick
);

  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] pre_q;

  assign tick = enable && (pre_q == div_q);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      div_q <= '0;
      pre_q <= '0;
    end else if (clear) begin
      pre_q <= '0;
    end else if (load) begin
      div_q <= div;
      pre_q <= '0;
    end else if (enable) begin
      if (tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_expire.sv
// Loadable down-counter with prescaler, pause,
// clear, sticky expiry flag and expiry pulse.
module countdown_timer_expire
  import timer_pkg::*;
#(
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int DIV_BITS     = DEF_DIV_BITS
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_START,
  input  logic [COUNTER_BITS-1:0] i_LOAD_VAL,
  input  logic [DIV_BITS-1:0]     i_DIV,
  input  logic                    i_PAUSE,
  input  logic                    i_CLEAR,
  output logic [COUNTER_BITS-1:0] o_COUNT,
  output logic                    o_BUSY,
  output logic                    o_EXPIRED,
  output logic                    o_EXPIRE_PULSE
);

  timer_state_e            state_q;
  timer_state_e            state_d;
  logic [COUNTER_BITS-1:0] count_q;
  logic [COUNTER_BITS-1:0] count_d;
  logic                    pulse_q;
  logic                    expire_ev;
  logic                    pre_en;
  logic                    tick;
  logic                    do_load;

  assign do_load = i_START && !i_CLEAR;

  // The cycle that leaves PAUSED also counts, so
  // each paused cycle costs exactly one cycle.
  assign pre_en = !i_CLEAR && !i_START &&
                  !i_PAUSE && is_busy(state_q);

  prescaler_tick #(
    .DIV_BITS (DIV_BITS)
  ) u_pre (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .load    (do_load),
    .div     (i_DIV),
    .enable  (pre_en),
    .clear   (i_CLEAR),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expire_ev = 1'b0;
    if (i_CLEAR) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (i_START) begin
      count_d = i_LOAD_VAL;
      if (i_LOAD_VAL != '0) begin
        state_d = ST_RUN;
      end else begin
        state_d   = ST_EXPIRED;
        expire_ev = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_PAUSE) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!i_PAUSE) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          count_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (tick) begin
        if (count_q <= COUNTER_BITS'(1)) begin
          count_d   = '0;
          state_d   = ST_EXPIRED;
          expire_ev = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= expire_ev;
    end
  end

  assign o_COUNT        = count_q;
  assign o_BUSY         = is_busy(state_q);
  assign o_EXPIRED      = (state_q == ST_EXPIRED);
  assign o_EXPIRE_PULSE = pulse_q;

endmodule
